// File: rtl/aemb2_pkg.sv
// Shared branch-unit definitions: opcodes, condition codes,
// per-thread branch FSM states and a thread-id width helper.
package aemb2_pkg;

  localparam logic [5:0] OPC_RTD  = 6'o55;
  localparam logic [5:0] OPC_BRU0 = 6'o46;
  localparam logic [5:0] OPC_BRU1 = 6'o56;
  localparam logic [5:0] OPC_BCC0 = 6'o47;
  localparam logic [5:0] OPC_BCC1 = 6'o57;

  localparam logic [2:0] CC_EQ = 3'd0;
  localparam logic [2:0] CC_NE = 3'd1;
  localparam logic [2:0] CC_LT = 3'd2;
  localparam logic [2:0] CC_LE = 3'd3;
  localparam logic [2:0] CC_GT = 3'd4;
  localparam logic [2:0] CC_GE = 3'd5;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DSLOT,
    ST_FLUSH
  } brst_t;

  function automatic int tw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aemb2_brcc_thr.sv
// Per-thread branch window FSM: tracks delay slot and
// non-delayed flush window, and latches delay-slot branch errors.
module aemb2_brcc_thr
  import aemb2_pkg::*;
#(
  parameter int FLUSH_CYC = 2
) (
  input  logic gclk,
  input  logic grst,
  input  logic dena,
  input  logic hit,
  input  logic take,
  input  logic dly,
  input  logic brn,
  output logic squash,
  output logic dslot,
  output logic flush,
  output logic derr
);

  brst_t      st;
  logic [3:0] cnt;

  assign flush  = (st == ST_FLUSH);
  assign dslot  = (st == ST_DSLOT);
  assign squash = hit & flush;

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      st   <= ST_RUN;
      cnt  <= '0;
      derr <= 1'b0;
    end else if (dena) begin
      unique case (st)
        ST_RUN: begin
          if (hit && take) begin
            if (dly) begin
              st <= ST_DSLOT;
            end else begin
              st  <= ST_FLUSH;
              cnt <= 4'(FLUSH_CYC);
            end
          end
        end
        ST_DSLOT: begin
          if (hit) begin
            st <= ST_RUN;
            if (brn) derr <= 1'b1;
          end
        end
        ST_FLUSH: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) st <= ST_RUN;
        end
        default: st <= ST_RUN;
      endcase
    end
  end

endmodule

// File: rtl/aemb2_brcc_mt.sv
// Multithreaded branch/condition unit: evaluates branch conditions
// in OF and registers the per-thread branch decision into EX.
module aemb2_brcc_mt
  import aemb2_pkg::*;
#(
  parameter int DW        = 32,
  parameter int NTHR      = 2,
  parameter int FLUSH_CYC = 2,
  parameter int UCMP      = 0,
  localparam int TW       = tw_of(NTHR)
) (
  input  logic            gclk,
  input  logic            grst,
  input  logic            dena,
  input  logic            vld_of,
  input  logic [TW-1:0]   thr_of,
  input  logic [5:0]      opc_of,
  input  logic [4:0]      ra_of,
  input  logic [4:0]      rd_of,
  input  logic [DW-1:0]   opd_of,
  output logic [1:0]      bra_ex,
  output logic [TW-1:0]   bthr_ex,
  output logic            sqsh_ex,
  output logic [NTHR-1:0] flush_ex,
  output logic [NTHR-1:0] derr_ex
);

  logic is_rtd, is_bru, is_bcc, brn;
  logic eq, lt, cond, take, dly;
  logic sq, fnt, eff;
  logic [NTHR-1:0] hit, squash_v, dslot_v;
  logic unused;

  assign unused = ^{ra_of[3:0], rd_of[3]};

  always_comb begin
    is_rtd = (opc_of == OPC_RTD);
    is_bru = (opc_of == OPC_BRU0) || (opc_of == OPC_BRU1);
    is_bcc = (opc_of == OPC_BCC0) || (opc_of == OPC_BCC1);
    brn    = is_rtd | is_bru | is_bcc;
    eq     = (opd_of == '0);
    // unsigned compare: nothing is below zero
    lt     = (UCMP != 0 && rd_of[3]) ? 1'b0 : opd_of[DW-1];
    cond   = 1'b0;
    case (rd_of[2:0])
      CC_EQ:   cond = eq;
      CC_NE:   cond = ~eq;
      CC_LT:   cond = lt;
      CC_LE:   cond = lt | eq;
      CC_GT:   cond = ~(lt | eq);
      CC_GE:   cond = ~lt;
      default: cond = 1'b0;
    endcase
    take = is_rtd | is_bru | (is_bcc & cond);
    dly  = rd_of[4];
    unique case (1'b1)
      is_rtd:  dly = 1'b1;
      is_bru:  dly = ra_of[4];
      default: dly = rd_of[4];
    endcase
  end

  for (genvar t = 0; t < NTHR; t++) begin : g_thr
    assign hit[t] = vld_of & ((NTHR == 1) || (thr_of == TW'(t)));

    aemb2_brcc_thr #(
      .FLUSH_CYC(FLUSH_CYC)
    ) u_thr (
      .gclk  (gclk),
      .grst  (grst),
      .dena  (dena),
      .hit   (hit[t]),
      .take  (take),
      .dly   (dly),
      .brn   (brn),
      .squash(squash_v[t]),
      .dslot (dslot_v[t]),
      .flush (flush_ex[t]),
      .derr  (derr_ex[t])
    );
  end

  assign sq  = |squash_v;
  assign fnt = |(dslot_v & hit);
  assign eff = vld_of & take & ~sq & ~fnt;

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      bra_ex  <= 2'b00;
      bthr_ex <= '0;
      sqsh_ex <= 1'b0;
    end else if (dena) begin
      bra_ex  <= {eff, eff & dly};
      bthr_ex <= thr_of;
      sqsh_ex <= sq;
    end
  end

endmodule

// File: tb/tb_aemb2_brcc_mt.sv
// Directed bench for aemb2_brcc_mt: signed and unsigned instances
// share stimulus; each task checks its own scenario.
module tb_aemb2_brcc_mt;

  logic        gclk, grst, dena, vld_of;
  logic [0:0]  thr_of;
  logic [5:0]  opc_of;
  logic [4:0]  ra_of, rd_of;
  logic [31:0] opd_of;

  logic [1:0] bra_ex, bra_u;
  logic [0:0] bthr_ex, bthr_u;
  logic       sqsh_ex, sqsh_u;
  logic [1:0] flush_ex, flush_u, derr_ex, derr_u;

  int passed = 0;
  int total  = 0;

  aemb2_brcc_mt #(.DW(32), .NTHR(2), .FLUSH_CYC(2), .UCMP(0)) dut (
    .gclk(gclk), .grst(grst), .dena(dena), .vld_of(vld_of),
    .thr_of(thr_of), .opc_of(opc_of), .ra_of(ra_of), .rd_of(rd_of),
    .opd_of(opd_of), .bra_ex(bra_ex), .bthr_ex(bthr_ex),
    .sqsh_ex(sqsh_ex), .flush_ex(flush_ex), .derr_ex(derr_ex)
  );

  aemb2_brcc_mt #(.DW(32), .NTHR(2), .FLUSH_CYC(2), .UCMP(1)) dut_u (
    .gclk(gclk), .grst(grst), .dena(dena), .vld_of(vld_of),
    .thr_of(thr_of), .opc_of(opc_of), .ra_of(ra_of), .rd_of(rd_of),
    .opd_of(opd_of), .bra_ex(bra_u), .bthr_ex(bthr_u),
    .sqsh_ex(sqsh_u), .flush_ex(flush_u), .derr_ex(derr_u)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic drive(input logic v, input logic [0:0] t,
                       input logic [5:0] o, input logic [4:0] a,
                       input logic [4:0] r, input logic [31:0] d);
    vld_of = v; thr_of = t; opc_of = o;
    ra_of = a; rd_of = r; opd_of = d;
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 6'o00, 5'd0, 5'd0, 32'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    dena = 1'b1;
    drive(1'b0, 1'b0, 6'o00, 5'd0, 5'd0, 32'd0);
    grst = 1'b1;
    tick();
    grst = 1'b0;
  endtask

  task automatic test_reset();
    dena = 1'b1;
    drive(1'b0, 1'b0, 6'o00, 5'd0, 5'd0, 32'd0);
    grst = 1'b1;
    #3;
    total++;
    if ({bra_ex, bthr_ex, sqsh_ex, flush_ex, derr_ex} !== 8'h00)
      $display("FAIL reset_outputs got %h exp 00",
               {bra_ex, bthr_ex, sqsh_ex, flush_ex, derr_ex});
    else passed++;
    tick();
    grst = 1'b0;
  endtask

  task automatic test_bcc_flush();
    do_reset();
    drive(1'b1, 1'b0, 6'o47, 5'd0, 5'b00000, 32'd0);
    tick();
    total++;
    if (bra_ex !== 2'b10 || bthr_ex !== 1'b0)
      $display("FAIL bcc_eq_bra got %b/%b exp 10/0", bra_ex, bthr_ex);
    else passed++;
    total++;
    if (flush_ex !== 2'b01)
      $display("FAIL bcc_flush_c1 got %b exp 01", flush_ex);
    else passed++;
    // thread 0 issues inside its own window and must be squashed
    drive(1'b1, 1'b0, 6'o47, 5'd0, 5'b00000, 32'd0);
    tick();
    total++;
    if (flush_ex !== 2'b01 || sqsh_ex !== 1'b1 || bra_ex !== 2'b00)
      $display("FAIL bcc_flush_c2 got f%b s%b b%b exp f01 s1 b00",
               flush_ex, sqsh_ex, bra_ex);
    else passed++;
    idle(1);
    total++;
    if (flush_ex !== 2'b00 || sqsh_ex !== 1'b0)
      $display("FAIL bcc_flush_end got f%b s%b exp f00 s0",
               flush_ex, sqsh_ex);
    else passed++;
  endtask

  task automatic test_dslot();
    do_reset();
    drive(1'b1, 1'b1, 6'o46, 5'b10000, 5'd0, 32'd0);
    tick();
    total++;
    if (bra_ex !== 2'b11 || bthr_ex !== 1'b1)
      $display("FAIL bru_delay got %b/%b exp 11/1", bra_ex, bthr_ex);
    else passed++;
    drive(1'b1, 1'b1, 6'o47, 5'd0, 5'b00000, 32'd0);
    tick();
    total++;
    if (bra_ex !== 2'b00 || derr_ex !== 2'b10 || flush_ex !== 2'b00)
      $display("FAIL dslot_branch got b%b d%b f%b exp b00 d10 f00",
               bra_ex, derr_ex, flush_ex);
    else passed++;
    drive(1'b1, 1'b1, 6'o47, 5'd0, 5'b00000, 32'd0);
    tick();
    total++;
    if (bra_ex !== 2'b10 || flush_ex !== 2'b10 || derr_ex !== 2'b10)
      $display("FAIL after_dslot got b%b f%b d%b exp b10 f10 d10",
               bra_ex, flush_ex, derr_ex);
    else passed++;
    idle(2);
  endtask

  task automatic test_cond_codes();
    logic [2:0]  cc  [7] = '{3'd6, 3'd7, 3'd1, 3'd3, 3'd4, 3'd4, 3'd0};
    logic [31:0] opd [7] = '{32'd0, 32'd5, 32'd5, 32'd0, 32'd5,
                             32'd0, 32'd1};
    logic [1:0]  exp [7] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b10,
                             2'b00, 2'b00};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 6'o47, 5'd0, {2'b00, cc[i]}, opd[i]);
      tick();
      total++;
      if (bra_ex !== exp[i])
        $display("FAIL cond_%0d_cc%0d got %b exp %b",
                 i, cc[i], bra_ex, exp[i]);
      else passed++;
      if (cc[i] >= 3'd6) begin
        total++;
        if (^{bra_ex, bthr_ex, sqsh_ex, flush_ex, derr_ex} === 1'bx)
          $display("FAIL cond_noX_cc%0d got %b exp no X", cc[i],
                   {bra_ex, bthr_ex, sqsh_ex, flush_ex, derr_ex});
        else passed++;
      end
      idle(2);
    end
  endtask

  task automatic test_unsigned();
    do_reset();
    drive(1'b1, 1'b0, 6'o47, 5'd0, 5'b01010, 32'h8000_0000);
    tick();
    total++;
    if (bra_ex !== 2'b10)
      $display("FAIL lt_signed got %b exp 10", bra_ex);
    else passed++;
    total++;
    if (bra_u !== 2'b00)
      $display("FAIL lt_unsigned got %b exp 00", bra_u);
    else passed++;
    idle(2);
    drive(1'b1, 1'b0, 6'o47, 5'd0, 5'b01101, 32'h8000_0000);
    tick();
    total++;
    if (bra_ex !== 2'b00 || bra_u !== 2'b10)
      $display("FAIL ge_sign_unsign got %b/%b exp 00/10", bra_ex, bra_u);
    else passed++;
    idle(2);
  endtask

  task automatic test_multithread();
    do_reset();
    drive(1'b1, 1'b0, 6'o47, 5'd0, 5'b00000, 32'd0);
    tick();
    drive(1'b1, 1'b1, 6'o55, 5'd0, 5'd0, 32'd0);
    tick();
    total++;
    if (bra_ex !== 2'b11 || bthr_ex !== 1'b1 || sqsh_ex !== 1'b0)
      $display("FAIL mt_rtd got b%b t%b s%b exp b11 t1 s0",
               bra_ex, bthr_ex, sqsh_ex);
    else passed++;
    drive(1'b1, 1'b0, 6'o47, 5'd0, 5'b00000, 32'd0);
    tick();
    total++;
    if (sqsh_ex !== 1'b1 || bra_ex !== 2'b00 || flush_ex !== 2'b00)
      $display("FAIL mt_squash got s%b b%b f%b exp s1 b00 f00",
               sqsh_ex, bra_ex, flush_ex);
    else passed++;
    drive(1'b1, 1'b1, 6'o00, 5'd0, 5'd0, 32'd0);
    tick();
    total++;
    if (bra_ex !== 2'b00 || derr_ex !== 2'b00 || sqsh_ex !== 1'b0)
      $display("FAIL mt_dslot_plain got b%b d%b s%b exp b00 d00 s0",
               bra_ex, derr_ex, sqsh_ex);
    else passed++;
  endtask

  task automatic test_hold_async_reset();
    do_reset();
    drive(1'b1, 1'b0, 6'o47, 5'd0, 5'b00000, 32'd0);
    tick();
    dena = 1'b0;
    drive(1'b1, 1'b1, 6'o55, 5'd0, 5'd0, 32'd0);
    tick();
    tick();
    total++;
    if (bra_ex !== 2'b10 || flush_ex !== 2'b01 || bthr_ex !== 1'b0)
      $display("FAIL dena_hold got b%b f%b t%b exp b10 f01 t0",
               bra_ex, flush_ex, bthr_ex);
    else passed++;
    #2;
    grst = 1'b1;
    #1;
    total++;
    if ({bra_ex, bthr_ex, sqsh_ex, flush_ex, derr_ex} !== 8'h00)
      $display("FAIL async_reset got %h exp 00",
               {bra_ex, bthr_ex, sqsh_ex, flush_ex, derr_ex});
    else passed++;
    #1;
    grst = 1'b0;
    dena = 1'b1;
    drive(1'b1, 1'b0, 6'o47, 5'd0, 5'b00000, 32'd0);
    tick();
    total++;
    if (bra_ex !== 2'b10 || flush_ex !== 2'b01 || sqsh_ex !== 1'b0)
      $display("FAIL post_reset got b%b f%b s%b exp b10 f01 s0",
               bra_ex, flush_ex, sqsh_ex);
    else passed++;
    idle(2);
  endtask

  initial begin
    grst = 1'b0;
    dena = 1'b1;
    drive(1'b0, 1'b0, 6'o00, 5'd0, 5'd0, 32'd0);
    test_reset();
    test_bcc_flush();
    test_dslot();
    test_cond_codes();
    test_unsigned();
    test_multithread();
    test_hold_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/aemb2_brcc_mt.md
AEMB2_BRCC_MT -- requirements
Module: aemb2_brcc_mt

Interface
REQ-001 SHALL provide parameter DW, default 32, meaning operand width in bits (DW >= 8).
REQ-002 SHALL provide parameter NTHR, default 2, meaning hardware thread count (power of two, 1..8); TW = max(1, log2 NTHR).
REQ-003 SHALL provide parameter FLUSH_CYC, default 2, meaning squash window after a non-delayed taken branch (1..15).
REQ-004 SHALL provide parameter UCMP, default 0, meaning 1 enables unsigned compares when rd_of[3]=1.
REQ-005 gclk  in  1  sole clock, all flops on rising edge.
REQ-006 grst  in  1  reset, asynchronous, active-high.
REQ-007 dena  in  1  pipeline advance enable; low freezes all state and outputs.
REQ-008 vld_of  in  1  operand-fetch slot holds a valid instruction.
REQ-009 thr_of  in  TW  thread id of the OF-stage instruction.
REQ-010 opc_of  in  6  opcode; ra_of  in  5; rd_of  in  5  register fields.
REQ-011 opd_of  in  DW  compare operand.
REQ-012 bra_ex  out  2  [1]=branch taken, [0]=delay slot follows.
REQ-013 bthr_ex  out  TW  thread owning bra_ex.
REQ-014 sqsh_ex  out  1  current EX instruction squashed (flush window).
REQ-015 flush_ex  out  NTHR  per-thread flush-window-active mask.
REQ-016 derr_ex  out  NTHR  sticky per-thread branch-in-delay-slot error.

Function
REQ-017 Decode SHALL be: RTD opc=055 octal; BRU opc=046/056; BCC opc=047/057; all others non-branch.
REQ-018 Conditions SHALL use rd_of[2:0]: 0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE; codes 6,7 SHALL evaluate not-taken (never X).
REQ-019 EQ SHALL be opd_of==0; LT SHALL be opd_of[DW-1], or constant 0 when UCMP=1 and rd_of[3]=1 (unsigned: LT never, LE=EQ, GT=NE, GE=1).
REQ-020 Taken SHALL be RTD | BRU | (BCC & cond); delay bit SHALL be ra_of[4] for BRU, else rd_of[4]; RTD SHALL always set delay=1.
REQ-021 Results SHALL register with latency 1 on gclk when dena=1; vld_of=0 or squashed input SHALL register bra_ex=00.
REQ-022 Each thread SHALL own a FSM with states RUN, DSLOT, FLUSH.
REQ-023 RUN: taken with delay -> DSLOT; taken without delay -> FLUSH, counter loaded FLUSH_CYC; else RUN.
REQ-024 DSLOT: next valid instruction of that thread executes normally, then -> RUN; if it is a branch it SHALL be forced not-taken and set derr_ex[t].
REQ-025 FLUSH: each dena cycle decrements counter; valid instructions of that thread SHALL be squashed (sqsh_ex=1, bra_ex=00); counter 1 -> RUN.
REQ-026 Other threads SHALL be unaffected by a thread's DSLOT/FLUSH state.
REQ-027 flush_ex[t] SHALL be 1 exactly while thread t is in FLUSH.
REQ-028 derr_ex bits SHALL stay set until reset.
REQ-029 dena=0 SHALL hold FSM state, counters and outputs unchanged.

Reset
REQ-030 grst SHALL asynchronously force all FSMs to RUN, counters 0, bra_ex=00, bthr_ex=0, sqsh_ex=0, flush_ex=0, derr_ex=0.
REQ-031 Reset mid-FLUSH or mid-DSLOT SHALL abandon the window; first post-reset instruction SHALL evaluate normally.

Structure
REQ-032 Opcode constants (RTD/BRU/BCC), condition codes and FSM state encoding SHALL live in shared package aemb2_pkg.
REQ-033 Per-thread FSM+counter SHALL be sub-module aemb2_brcc_thr, instantiated NTHR times; condition evaluation stays in top.

Verification
REQ-034 BCC opc=047, rd=00000 (EQ), opd=0, thr=0 -> next cycle bra_ex=10, bthr_ex=0, flush_ex=01 for 2 cycles.
REQ-035 BRU opc=046, ra=10000, thr=1 -> bra_ex=11; next thr1 BCC taken -> bra_ex=00, derr_ex=10.
REQ-036 BCC LT with opd=0x80000000, rd=01010, UCMP=1 -> not taken; same with UCMP=0 -> bra_ex=10.
REQ-037 rd[2:0]=6, opd=0 -> bra_ex=00, no X on any output.
REQ-038 thr0 in FLUSH, thr1 RTD issued -> thr1 bra_ex=11 unsquashed; thr0 instruction same window -> sqsh_ex=1.
REQ-039 Assert grst during FLUSH with dena=0 -> outputs zero immediately without gclk edge.
